// File: rtl/rd_slave_arbiter.sv
// Per-slave read-channel arbiter: round-robin grant between two masters, held from AR through RLAST.
// Optional watchdog (rd_timeout port and idle counter) is built when RD_ARB_TIMEOUT_EN is defined.
module rd_slave_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       m1_rd_req,
  input  logic       m2_rd_req,
  input  logic [7:0] m1_ARLEN,
  input  logic [7:0] m2_ARLEN,
  input  logic       s_ARREADY,
  input  logic       s_RVALID,
  input  logic       s_RLAST,
  input  logic       m1_RREADY,
  input  logic       m2_RREADY,
  output logic [1:0] mas_sel,
  output logic       arb_busy,
  output logic       len_err
`ifdef RD_ARB_TIMEOUT_EN
  ,
  output logic       rd_timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state_reg;
  logic [7:0] beat_cnt_reg;
  logic [7:0] len_q_reg;
  logic       last_gnt_reg;  // 1 = master2 received the most recent grant

  logic g_req;
  logic g_rready;
  logic addr_hs;
  logic r_beat;
  logic any_req;
  logic pick_m1;
  logic to_fire;

  // Granted-master views are taken from the registered grant, so no combinational path through arbitration.
  assign g_req    = (mas_sel[0] & m1_rd_req) | (mas_sel[1] & m2_rd_req);
  assign g_rready = (mas_sel[0] & m1_RREADY) | (mas_sel[1] & m2_RREADY);
  assign addr_hs  = (state_reg == ADDR) & g_req & s_ARREADY;
  assign r_beat   = (state_reg == DATA) & s_RVALID & g_rready;
  assign any_req  = m1_rd_req | m2_rd_req;
  assign pick_m1  = m1_rd_req & (~m2_rd_req | last_gnt_reg);

`ifdef RD_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_reg;

  // Any forward progress (AR handshake or R beat) defers the watchdog.
  assign to_fire = (state_reg != IDLE) & ~addr_hs & ~r_beat &
                   (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      to_cnt_reg <= '0;
    end else if ((state_reg == IDLE) || addr_hs || r_beat || to_fire) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;

  // TIMEOUT_CYCLES has no effect without the watchdog.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg    <= IDLE;
      mas_sel      <= 2'b00;
      arb_busy     <= 1'b0;
      len_err      <= 1'b0;
      beat_cnt_reg <= 8'd0;
      len_q_reg    <= 8'd0;
      last_gnt_reg <= 1'b1;
`ifdef RD_ARB_TIMEOUT_EN
      rd_timeout   <= 1'b0;
`endif
    end else begin
      len_err <= 1'b0;
`ifdef RD_ARB_TIMEOUT_EN
      rd_timeout <= to_fire;
`endif
      if (to_fire) begin
        state_reg <= IDLE;
        mas_sel   <= 2'b00;
        arb_busy  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (any_req) begin
              state_reg <= ADDR;
              arb_busy  <= 1'b1;
              if (pick_m1) begin
                mas_sel      <= 2'b01;
                len_q_reg    <= m1_ARLEN;
                last_gnt_reg <= 1'b0;
              end else begin
                mas_sel      <= 2'b10;
                len_q_reg    <= m2_ARLEN;
                last_gnt_reg <= 1'b1;
              end
            end
          end
          ADDR: begin
            // A dropped request keeps the grant; the other master waits for IDLE.
            if (addr_hs) begin
              state_reg    <= DATA;
              beat_cnt_reg <= 8'd0;
            end
          end
          DATA: begin
            if (r_beat) begin
              if (s_RLAST) begin
                len_err   <= (beat_cnt_reg != len_q_reg);
                state_reg <= IDLE;
                mas_sel   <= 2'b00;
                arb_busy  <= 1'b0;
              end else begin
                len_err      <= (beat_cnt_reg == len_q_reg);
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            mas_sel   <= 2'b00;
            arb_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rd_slave_arbiter.sv
// Self-checking bench for rd_slave_arbiter: grant scoreboard, burst length checks, reset and watchdog.
module tb_rd_slave_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       m1_rd_req, m2_rd_req;
  logic [7:0] m1_ARLEN, m2_ARLEN;
  logic       s_ARREADY, s_RVALID, s_RLAST;
  logic       m1_RREADY, m2_RREADY;
  logic [1:0] mas_sel;
  logic       arb_busy, len_err;
`ifdef RD_ARB_TIMEOUT_EN
  logic       rd_timeout;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];
  logic       last_m2;  // model of last grant owner (1 = master2)

  rd_slave_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .m1_rd_req (m1_rd_req),
    .m2_rd_req (m2_rd_req),
    .m1_ARLEN  (m1_ARLEN),
    .m2_ARLEN  (m2_ARLEN),
    .s_ARREADY (s_ARREADY),
    .s_RVALID  (s_RVALID),
    .s_RLAST   (s_RLAST),
    .m1_RREADY (m1_RREADY),
    .m2_RREADY (m2_RREADY),
    .mas_sel   (mas_sel),
    .arb_busy  (arb_busy),
    .len_err   (len_err)
`ifdef RD_ARB_TIMEOUT_EN
    ,
    .rd_timeout(rd_timeout)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic idle_inputs();
    m1_rd_req = 1'b0; m2_rd_req = 1'b0;
    m1_ARLEN  = 8'd0; m2_ARLEN  = 8'd0;
    s_ARREADY = 1'b0; s_RVALID  = 1'b0; s_RLAST = 1'b0;
    m1_RREADY = 1'b0; m2_RREADY = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    idle_inputs();
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    last_m2 = 1'b1;
  endtask

  // One full read transaction; expected grant goes into the scoreboard when requests are driven.
  task automatic run_burst(input logic [1:0] req, input logic [7:0] len1, input logic [7:0] len2,
                           input int nbeats, input int stall, input string name);
    logic [1:0] exp_sel;
    logic [1:0] got;
    logic [7:0] len;
    int exp_errs, errs, wait_n;
    exp_sel = (req == 2'b11) ? (last_m2 ? 2'b01 : 2'b10) : req;
    last_m2 = exp_sel[1];
    len = exp_sel[0] ? len1 : len2;
    exp_errs = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (b == nbeats - 1) begin
        if (b != int'(len)) exp_errs++;
      end else if (b == int'(len)) begin
        exp_errs++;
      end
    end
    exp_q.push_back(exp_sel);
    @(negedge ACLK);
    m1_rd_req = req[0]; m2_rd_req = req[1];
    m1_ARLEN = len1; m2_ARLEN = len2;
    wait_n = 0;
    do begin
      @(negedge ACLK);
      wait_n++;
    end while (mas_sel == 2'b00 && wait_n < 8);
    got = exp_q.pop_front();
    n_checks++;
    if (mas_sel !== got) $display("FAIL %s grant: got %b expected %b", name, mas_sel, got);
    else n_pass++;
    n_checks++;
    if (wait_n != 1) $display("FAIL %s grant_latency: got %0d expected 1", name, wait_n);
    else n_pass++;
    s_ARREADY = 1'b1;
    @(negedge ACLK);
    m1_rd_req = 1'b0; m2_rd_req = 1'b0; s_ARREADY = 1'b0;
    s_RVALID = 1'b1; s_RLAST = 1'b0; m1_RREADY = 1'b0; m2_RREADY = 1'b0;
    repeat (stall) @(negedge ACLK);
    errs = 0;
    for (int b = 0; b < nbeats; b++) begin
      m1_RREADY = exp_sel[0]; m2_RREADY = exp_sel[1];
      s_RVALID = 1'b1; s_RLAST = (b == nbeats - 1);
      @(negedge ACLK);
      if (len_err) errs++;
      if (b == nbeats - 2) begin
        n_checks++;
        if (mas_sel !== exp_sel || arb_busy !== 1'b1)
          $display("FAIL %s hold: got sel=%b busy=%b expected sel=%b busy=1", name, mas_sel, arb_busy, exp_sel);
        else n_pass++;
      end
    end
    s_RVALID = 1'b0; s_RLAST = 1'b0; m1_RREADY = 1'b0; m2_RREADY = 1'b0;
    n_checks++;
    if (mas_sel !== 2'b00 || arb_busy !== 1'b0)
      $display("FAIL %s release: got sel=%b busy=%b expected sel=00 busy=0", name, mas_sel, arb_busy);
    else n_pass++;
    @(negedge ACLK);
    if (len_err) errs++;
    n_checks++;
    if (errs != exp_errs) $display("FAIL %s len_err_pulses: got %0d expected %0d", name, errs, exp_errs);
    else n_pass++;
    $display("txn %s: sel=%b len=%0d beats=%0d stall=%0d len_err_pulses=%0d", name, exp_sel, len, nbeats, stall, errs);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    idle_inputs();
    repeat (3) @(negedge ACLK);
    n_checks++;
    if (mas_sel !== 2'b00 || arb_busy !== 1'b0 || len_err !== 1'b0)
      $display("FAIL reset_state: got sel=%b busy=%b err=%b expected 00/0/0", mas_sel, arb_busy, len_err);
    else n_pass++;
    ARESET = 1'b0;
    last_m2 = 1'b1;
    @(negedge ACLK);
    n_checks++;
    if (mas_sel !== 2'b00 || arb_busy !== 1'b0)
      $display("FAIL idle_no_req: got sel=%b busy=%b expected 00/0", mas_sel, arb_busy);
    else n_pass++;
    $display("txn reset: sel=%b busy=%b", mas_sel, arb_busy);
  endtask

  task automatic test_single();
    run_burst(2'b01, 8'd3, 8'd0, 4, 0, "single_m1_len3");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) run_burst(2'b11, 8'd0, 8'd0, 1, 0, "rr_tie");
  endtask

  task automatic test_short_burst();
    run_burst(2'b10, 8'd0, 8'd1, 1, 0, "short_m2_len1");
  endtask

  task automatic test_overrun();
    run_burst(2'b01, 8'd0, 8'd0, 3, 0, "overrun_len0");
  endtask

  task automatic test_rready_stall();
    run_burst(2'b01, 8'd1, 8'd0, 2, 5, "rready_stall");
  endtask

  task automatic test_addr_hold();
    @(negedge ACLK);
    m1_rd_req = 1'b1; m1_ARLEN = 8'd0;
    @(negedge ACLK);
    last_m2 = 1'b0;
    m1_rd_req = 1'b0; m2_rd_req = 1'b1; s_ARREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    n_checks++;
    if (mas_sel !== 2'b01) $display("FAIL addr_hold: got %b expected 01", mas_sel);
    else n_pass++;
    m2_rd_req = 1'b0; m1_rd_req = 1'b1;
    @(negedge ACLK);
    m1_rd_req = 1'b0; s_ARREADY = 1'b0;
    s_RVALID = 1'b1; s_RLAST = 1'b1; m1_RREADY = 1'b1;
    @(negedge ACLK);
    s_RVALID = 1'b0; s_RLAST = 1'b0; m1_RREADY = 1'b0;
    n_checks++;
    if (mas_sel !== 2'b00 || len_err !== 1'b0)
      $display("FAIL addr_hold_release: got sel=%b err=%b expected 00/0", mas_sel, len_err);
    else n_pass++;
    $display("txn addr_hold: sel=%b", mas_sel);
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    m1_rd_req = 1'b1; m1_ARLEN = 8'd3;
    @(negedge ACLK);
    s_ARREADY = 1'b1;
    @(negedge ACLK);
    m1_rd_req = 1'b0; s_ARREADY = 1'b0;
    s_RVALID = 1'b1; m1_RREADY = 1'b1;
    @(negedge ACLK);
    s_RVALID = 1'b0; m1_RREADY = 1'b0;
    ARESET = 1'b1;
    #1;
    n_checks++;
    if (mas_sel !== 2'b00 || arb_busy !== 1'b0)
      $display("FAIL reset_mid: got sel=%b busy=%b expected 00/0", mas_sel, arb_busy);
    else n_pass++;
    $display("txn reset_mid: sel=%b busy=%b", mas_sel, arb_busy);
    @(negedge ACLK);
    ARESET = 1'b0;
    last_m2 = 1'b1;
    run_burst(2'b11, 8'd0, 8'd0, 1, 0, "post_reset_tie");
  endtask

`ifdef RD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    @(negedge ACLK);
    m1_rd_req = 1'b1; m1_ARLEN = 8'd0;
    @(negedge ACLK);
    last_m2 = 1'b0;
    s_ARREADY = 1'b1;
    @(negedge ACLK);
    m1_rd_req = 1'b0; s_ARREADY = 1'b0;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (rd_timeout !== 1'b1 && n < 40);
    n_checks++;
    if (n != 16) $display("FAIL timeout_cycles: got %0d expected 16", n);
    else n_pass++;
    n_checks++;
    if (mas_sel !== 2'b00 || len_err !== 1'b0)
      $display("FAIL timeout_release: got sel=%b err=%b expected 00/0", mas_sel, len_err);
    else n_pass++;
    @(negedge ACLK);
    n_checks++;
    if (rd_timeout !== 1'b0) $display("FAIL timeout_pulse: got %b expected 0", rd_timeout);
    else n_pass++;
    $display("txn timeout: cycles=%0d", n);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_short_burst();
    test_overrun();
    test_rready_stall();
    test_addr_hold();
    test_reset_mid();
`ifdef RD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
